msp_instr_decoder: RTL

- Sequential instruction decoder that produces the control word consumed by the 16-bit ALU: alu_sel[4:0], byte flag, register/addressing fields and extension words.
- Accepts MSP430-format instruction words one per handshake and gathers 0–2 extension words.
- Presents one registered decoded micro-op on a valid/ready output to the execute stage.

---
 rtl/msp_instr_decoder_if.sv | 42 ++++
 rtl/msp_instr_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/msp_instr_decoder_if.sv
// ---------------------------------------------------------------------------
// msp_instr_decoder_if : instruction-word input and decoded micro-op output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface msp_instr_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [4:0]  alu_sel;
  logic        byte_op;
  logic [3:0]  src_reg;
  logic [1:0]  as_mode;
  logic [3:0]  dst_reg;
  logic        ad_mode;
  logic [2:0]  jmp_cond;
  logic [15:0] jmp_off;
  logic [15:0] src_ext;
  logic        src_ext_vld;
  logic [15:0] dst_ext;
  logic        dst_ext_vld;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_kind, alu_sel, byte_op, src_reg, as_mode,
           dst_reg, ad_mode, jmp_cond, jmp_off, src_ext, src_ext_vld,
           dst_ext, dst_ext_vld
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_kind, alu_sel, byte_op, src_reg, as_mode,
           dst_reg, ad_mode, jmp_cond, jmp_off, src_ext, src_ext_vld,
           dst_ext, dst_ext_vld
  );
endinterface

`default_nettype wire

// File: rtl/msp_instr_decoder.sv
// ---------------------------------------------------------------------------
// msp_instr_decoder : MSP430 opcode + extension-word decoder for the ALU
// Optional macro DEC_ILLEGAL_TRAP_EN: illegal opcodes emit a trap micro-op.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module msp_instr_decoder #(
  parameter logic [3:0] PC_REG = 4'd0,
  parameter logic [3:0] CG_REG = 4'd3
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              flush,
  msp_instr_decoder_if.slave     bus
);

  typedef enum logic [1:0] {
    S_OPC     = 2'd0,
    S_SRC_EXT = 2'd1,
    S_DST_EXT = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [4:0]  alu_q, alu_d;
  logic        byte_q, byte_d;
  logic [3:0]  src_q, src_d;
  logic [1:0]  as_q, as_d;
  logic [3:0]  dst_q, dst_d;
  logic        ad_q, ad_d;
  logic [2:0]  cond_q, cond_d;
  logic [15:0] off_q, off_d;
  logic [15:0] sext_q, sext_d;
  logic        svld_q, svld_d;
  logic [15:0] dext_q, dext_d;
  logic        dvld_q, dvld_d;

  logic [15:0] w;
  logic        accept, is_dbl, is_sgl, is_jmp;
  logic [3:0]  dec_src;
  logic [1:0]  dec_as;
  logic        need_src, need_dst;
  logic [4:0]  dbl_alu;

  assign w        = bus.in_word;
  assign accept   = bus.in_valid & (state_q != S_OUT);
  assign is_dbl   = (w[15:12] >= 4'h4);
  assign is_sgl   = (w[15:10] == 6'b000100) && (w[9:7] != 3'b111);
  assign is_jmp   = (w[15:13] == 3'b001);
  // Single-op operands live in the low nibble, double-op sources in [11:8].
  assign dec_src  = is_dbl ? w[11:8] : w[3:0];
  assign dec_as   = w[5:4];
  assign need_src = (is_dbl | is_sgl) &&
                    (((dec_as == 2'b01) && (dec_src != CG_REG)) ||
                     ((dec_as == 2'b11) && (dec_src == PC_REG)));
  assign need_dst = is_dbl & w[7];

  always_comb begin
    dbl_alu = 5'd0;
    case (w[15:12])
      4'h4:    dbl_alu = 5'd0;
      4'h5:    dbl_alu = 5'd1;
      4'h6:    dbl_alu = 5'd2;
      4'h7:    dbl_alu = 5'd4;
      4'h8:    dbl_alu = 5'd3;
      4'h9:    dbl_alu = 5'd5;
      4'hA:    dbl_alu = 5'd6;
      4'hB:    dbl_alu = 5'd7;
      4'hC:    dbl_alu = 5'd8;
      4'hD:    dbl_alu = 5'd9;
      4'hE:    dbl_alu = 5'd10;
      4'hF:    dbl_alu = 5'd11;
      default: dbl_alu = 5'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    alu_d   = alu_q;
    byte_d  = byte_q;
    src_d   = src_q;
    as_d    = as_q;
    dst_d   = dst_q;
    ad_d    = ad_q;
    cond_d  = cond_q;
    off_d   = off_q;
    sext_d  = sext_q;
    svld_d  = svld_q;
    dext_d  = dext_q;
    dvld_d  = dvld_q;
    if (flush) begin
      state_d = S_OPC;
    end else begin
      case (state_q)
        S_OPC: begin
          if (accept && (is_dbl || is_sgl || is_jmp)) begin
            kind_d  = is_dbl ? 2'b00 : (is_sgl ? 2'b01 : 2'b10);
            alu_d   = is_dbl ? dbl_alu : (is_sgl ? {2'b10, w[9:7]} : 5'b01100);
            byte_d  = is_jmp ? 1'b0 : w[6];
            src_d   = is_jmp ? 4'd0 : dec_src;
            as_d    = is_jmp ? 2'b00 : dec_as;
            dst_d   = is_jmp ? 4'd0 : w[3:0];
            ad_d    = is_dbl & w[7];
            cond_d  = is_jmp ? w[12:10] : 3'd0;
            off_d   = is_jmp ? {{6{w[9]}}, w[9:0]} : 16'd0;
            sext_d  = 16'd0;
            svld_d  = 1'b0;
            dext_d  = 16'd0;
            dvld_d  = 1'b0;
            state_d = need_src ? S_SRC_EXT : (need_dst ? S_DST_EXT : S_OUT);
          end else if (accept) begin
`ifdef DEC_ILLEGAL_TRAP_EN
            kind_d  = 2'b11;
            alu_d   = 5'b01100;
            byte_d  = 1'b0;
            src_d   = 4'd0;
            as_d    = 2'b00;
            dst_d   = 4'd0;
            ad_d    = 1'b0;
            cond_d  = 3'd0;
            off_d   = 16'd0;
            sext_d  = w;
            svld_d  = 1'b1;
            dext_d  = 16'd0;
            dvld_d  = 1'b0;
            state_d = S_OUT;
`else
            state_d = S_OPC;
`endif
          end
        end
        S_SRC_EXT: begin
          if (accept) begin
            sext_d  = w;
            svld_d  = 1'b1;
            state_d = ((kind_q == 2'b00) && ad_q) ? S_DST_EXT : S_OUT;
          end
        end
        S_DST_EXT: begin
          if (accept) begin
            dext_d  = w;
            dvld_d  = 1'b1;
            state_d = S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) state_d = S_OPC;
        end
        default: state_d = S_OPC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OPC;
      kind_q  <= 2'b00;
      alu_q   <= 5'd0;
      byte_q  <= 1'b0;
      src_q   <= 4'd0;
      as_q    <= 2'b00;
      dst_q   <= 4'd0;
      ad_q    <= 1'b0;
      cond_q  <= 3'd0;
      off_q   <= 16'd0;
      sext_q  <= 16'd0;
      svld_q  <= 1'b0;
      dext_q  <= 16'd0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      alu_q   <= alu_d;
      byte_q  <= byte_d;
      src_q   <= src_d;
      as_q    <= as_d;
      dst_q   <= dst_d;
      ad_q    <= ad_d;
      cond_q  <= cond_d;
      off_q   <= off_d;
      sext_q  <= sext_d;
      svld_q  <= svld_d;
      dext_q  <= dext_d;
      dvld_q  <= dvld_d;
    end
  end

  assign bus.in_ready    = (state_q != S_OUT);
  assign bus.out_valid   = (state_q == S_OUT);
  assign bus.out_kind    = kind_q;
  assign bus.alu_sel     = alu_q;
  assign bus.byte_op     = byte_q;
  assign bus.src_reg     = src_q;
  assign bus.as_mode     = as_q;
  assign bus.dst_reg     = dst_q;
  assign bus.ad_mode     = ad_q;
  assign bus.jmp_cond    = cond_q;
  assign bus.jmp_off     = off_q;
  assign bus.src_ext     = sext_q;
  assign bus.src_ext_vld = svld_q;
  assign bus.dst_ext     = dext_q;
  assign bus.dst_ext_vld = dvld_q;

endmodule

`default_nettype wire
